// File: rtl/mem_copy_pkg.sv
// Shared types and defaults for the memory block-copy engine and port arbiter.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

  localparam int unsigned W_DEFAULT         = 8;
  localparam int unsigned A_DEFAULT         = 8;
  localparam int unsigned STALL_MAX_DEFAULT = 4;

  // Counter width able to hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_copy_ctrl.sv
// Block-copy engine sharing a single-port data memory with the CPU load/store path.
// CPU wins the port unless the engine has been blocked STALL_MAX cycles in a row.
module mem_copy_ctrl
  import mem_copy_pkg::*;
#(
  parameter int unsigned W         = W_DEFAULT,
  parameter int unsigned A         = A_DEFAULT,
  parameter int unsigned STALL_MAX = STALL_MAX_DEFAULT
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A-1:0] Len,
  input  logic         CpuReq,
  input  logic         CpuWrite,
  input  logic [A-1:0] CpuAddr,
  input  logic [W-1:0] CpuWData,
  output logic [W-1:0] CpuRData,
  output logic         CpuStall,
  output logic         MemWrite,
  output logic [A-1:0] MemAddress,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut,
  output logic         Busy,
  output logic         Done
);

  localparam int unsigned SW = cnt_width(STALL_MAX);

  copy_state_t   state_q, state_d;
  logic [A-1:0]  src_q, src_d;
  logic [A-1:0]  dst_q, dst_d;
  logic [A-1:0]  len_q, len_d;
  logic [A-1:0]  idx_q, idx_d;
  logic [W-1:0]  hold_q, hold_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;

  logic eng_want;
  logic force_slot;
  logic cpu_gnt;
  logic eng_gnt;

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Port arbitration and starvation counter.
  always_comb begin
    eng_want    = (state_q == READ) || (state_q == WRITE);
    force_slot  = (stall_cnt_q == SW'(STALL_MAX));
    cpu_gnt     = CpuReq && !force_slot;
    eng_gnt     = eng_want && !cpu_gnt;
    stall_cnt_d = stall_cnt_q;
    if (eng_gnt) begin
      stall_cnt_d = '0;
    end else if (cpu_gnt && eng_want && !force_slot) begin
      stall_cnt_d = stall_cnt_q + SW'(1);
    end
  end

  // Next-state and copy bookkeeping; the engine only advances on its own grant.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          len_d   = Len;
          idx_d   = '0;
          state_d = (Len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (eng_gnt) begin
          hold_d  = MemDataOut;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (eng_gnt) begin
          if (idx_q == len_q - A'(1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + A'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port mux and status outputs.
  always_comb begin
    MemWrite   = 1'b0;
    MemAddress = '0;
    MemDataIn  = '0;
    CpuStall   = CpuReq && eng_gnt;
    CpuRData   = MemDataOut;
    Busy       = (state_q != IDLE);
    Done       = (state_q == DONE);
    if (cpu_gnt) begin
      MemWrite   = CpuWrite;
      MemAddress = CpuAddr;
      MemDataIn  = CpuWData;
    end else if (eng_gnt) begin
      if (state_q == WRITE) begin
        MemWrite   = 1'b1;
        MemAddress = dst_q + idx_q;
        MemDataIn  = hold_q;
      end else begin
        MemAddress = src_q + idx_q;
      end
    end
  end

endmodule
